// File: rtl/alu_unit_pkg.sv
// Shared definitions for the ALU execution stage: ROB tag width, funct3 classes
// and the tagged result record broadcast on the CDB.
package alu_unit_pkg;

    localparam int ROB_TAG_W = 4;
    localparam int RS_SIZE   = 8;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SR   = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    typedef struct packed {
        logic [31:0]          value;
        logic [ROB_TAG_W-1:0] rob_id;
    } cdb_result_t;

endpackage

// File: rtl/alu_unit_core.sv
// Combinational RV32I integer datapath: funct3 class plus funct7[5] modifier
// selects add/sub, shifts, compares and bitwise logic.
module alu_core
    import alu_unit_pkg::*;
(
    input  logic [2:0]  op_L1,
    input  logic        op_L2,
    input  logic [31:0] opr1,
    input  logic [31:0] opr2,
    output logic [31:0] result
);

    logic [4:0] shamt;

    assign shamt = opr2[4:0];

    always_comb begin
        result = '0;
        case (op_L1)
            ALU_ADD:  result = op_L2 ? (opr1 - opr2) : (opr1 + opr2);
            ALU_SLL:  result = opr1 << shamt;
            ALU_SLT:  result = {31'b0, ($signed(opr1) < $signed(opr2))};
            ALU_SLTU: result = {31'b0, (opr1 < opr2)};
            ALU_XOR:  result = opr1 ^ opr2;
            ALU_SR:   result = op_L2 ? 32'($signed(opr1) >>> shamt) : (opr1 >> shamt);
            ALU_OR:   result = opr1 | opr2;
            ALU_AND:  result = opr1 & opr2;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_unit.sv
// ALU execution stage: computes issued ops, queues tagged results in a small FIFO
// and presents the head to the CDB with a valid/grant handshake.
module alu_unit
    import alu_unit_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ROB_W      = ROB_TAG_W
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             issue_valid,
    input  logic [2:0]       issue_op_L1,
    input  logic             issue_op_L2,
    input  logic [31:0]      issue_opr1,
    input  logic [31:0]      issue_opr2,
    input  logic [ROB_W-1:0] issue_rob_id,
    input  logic             cdb_grant,
    output logic             alu_valid,
    output logic [31:0]      alu_value,
    output logic [ROB_W-1:0] alu_dependency,
    output logic             alu_full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]       result;
    cdb_result_t       entries [FIFO_DEPTH];
    cdb_result_t       head_entry;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              active;
    logic              pop;
    logic              do_push;
    logic              at_capacity;

    alu_core u_core (
        .op_L1  (issue_op_L1),
        .op_L2  (issue_op_L2),
        .opr1   (issue_opr1),
        .opr2   (issue_opr2),
        .result (result)
    );

    assign active      = rdy_in && !flush_in;
    assign at_capacity = (count == CNT_W'(FIFO_DEPTH));
    assign pop         = active && alu_valid && cdb_grant;
    // A push into a full queue only lands when the head leaves in the same cycle.
    assign do_push     = active && issue_valid && (!at_capacity || pop);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_push) tail <= tail + PTR_W'(1);
                if (pop)     head <= head + PTR_W'(1);
                case ({do_push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry storage carries no reset; the count gates everything read from it.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            entries[tail].value  <= result;
            entries[tail].rob_id <= issue_rob_id;
        end
    end

    assign head_entry     = entries[head];
    assign alu_valid      = (count != '0);
    assign alu_value      = alu_valid ? head_entry.value : '0;
    assign alu_dependency = alu_valid ? head_entry.rob_id : '0;
    // One slot of slack because the RS sees this flag a cycle late.
    assign alu_full       = (count >= CNT_W'(FIFO_DEPTH - 1));

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_alu_unit;

    localparam int DEPTH = 4;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        flush_in;
    logic        issue_valid;
    logic [2:0]  issue_op_L1;
    logic        issue_op_L2;
    logic [31:0] issue_opr1;
    logic [31:0] issue_opr2;
    logic [3:0]  issue_rob_id;
    logic        cdb_grant;
    logic        alu_valid;
    logic [31:0] alu_value;
    logic [3:0]  alu_dependency;
    logic        alu_full;

    int checks   = 0;
    int failures = 0;

    logic [35:0] mq [$];

    alu_unit #(.FIFO_DEPTH(DEPTH), .ROB_W(4)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .rdy_in         (rdy_in),
        .flush_in       (flush_in),
        .issue_valid    (issue_valid),
        .issue_op_L1    (issue_op_L1),
        .issue_op_L2    (issue_op_L2),
        .issue_opr1     (issue_opr1),
        .issue_opr2     (issue_opr2),
        .issue_rob_id   (issue_rob_id),
        .cdb_grant      (cdb_grant),
        .alu_valid      (alu_valid),
        .alu_value      (alu_value),
        .alu_dependency (alu_dependency),
        .alu_full       (alu_full)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] ref_alu(input logic [2:0] l1, input logic l2,
                                            input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [31:0] ones;
        sh   = b % 32;
        ones = 32'hFFFF_FFFF;
        case (l1)
            3'd0: return l2 ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return (l2 && a[31]) ? ((a >> sh) | ~(ones >> sh)) : (a >> sh);
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic        m_valid();  return mq.size() != 0;               endfunction
    function automatic logic [31:0] m_value();  return (mq.size() != 0) ? mq[0][35:4] : 32'd0; endfunction
    function automatic logic [3:0]  m_dep();    return (mq.size() != 0) ? mq[0][3:0]  : 4'd0;  endfunction
    function automatic logic        m_full();   return mq.size() >= DEPTH - 1;       endfunction

    // Drive one cycle of stimulus, clock it, and advance the reference queue.
    task automatic cycle(input logic iv, input logic [2:0] l1, input logic l2,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                         input logic g, input logic fl, input logic rdy);
        bit popping;
        issue_valid  = iv;   issue_op_L1 = l1;  issue_op_L2 = l2;
        issue_opr1   = a;    issue_opr2  = b;   issue_rob_id = tag;
        cdb_grant    = g;    flush_in    = fl;  rdy_in       = rdy;
        @(posedge clk_in);
        if (rdy) begin
            if (fl) begin
                mq.delete();
            end else begin
                popping = g && (mq.size() != 0);
                if (iv && mq.size() == DEPTH && !popping) begin
                    failures++;
                    $display("FAIL overflow_protocol: push into full queue without pop (size=%0d)", mq.size());
                end
                if (popping) void'(mq.pop_front());
                if (iv && (mq.size() < DEPTH)) mq.push_back({ref_alu(l1, l2, a, b), tag});
            end
        end
        #1;
        issue_valid = 1'b0; cdb_grant = 1'b0; flush_in = 1'b0; rdy_in = 1'b1;
    endtask

    task automatic idle(input logic g);
        cycle(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 4'd0, g, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; issue_valid = 1'b0;
        issue_op_L1 = '0; issue_op_L2 = 1'b0; issue_opr1 = '0; issue_opr2 = '0;
        issue_rob_id = '0; cdb_grant = 1'b0;
        #12;
        checks++; if (alu_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", alu_valid); end
        checks++; if (alu_value !== 32'd0) begin failures++; $display("FAIL reset_value: got %h want 0", alu_value); end
        checks++; if (alu_dependency !== 4'd0) begin failures++; $display("FAIL reset_dep: got %0d want 0", alu_dependency); end
        checks++; if (alu_full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b want 0", alu_full); end
        @(negedge clk_in); rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        mq.delete();
    endtask

    task automatic test_arith();
        cycle(1'b1, 3'd0, 1'b1, 32'd5, 32'd7, 4'd3, 1'b1, 1'b0, 1'b1);
        checks++; if (alu_valid !== 1'b1) begin failures++; $display("FAIL sub_valid: got %b want 1", alu_valid); end
        checks++; if (alu_value !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sub_value: got %h want fffffffe", alu_value); end
        checks++; if (alu_dependency !== 4'd3) begin failures++; $display("FAIL sub_dep: got %0d want 3", alu_dependency); end
        idle(1'b1);
        checks++; if (alu_valid !== 1'b0) begin failures++; $display("FAIL sub_drained: got %b want 0", alu_valid); end
    endtask

    task automatic test_shift_compare();
        logic [2:0]  l1 [5] = '{3'd5, 3'd2, 3'd3, 3'd1, 3'd5};
        logic        l2 [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] a  [5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000};
        logic [31:0] b  [5] = '{32'h24, 32'd1, 32'd1, 32'd31, 32'h24};
        logic [31:0] ex [5] = '{32'hF800_0000, 32'd1, 32'd0, 32'h8000_0000, 32'h0800_0000};
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, l1[i], l2[i], a[i], b[i], 4'(i + 8), 1'b0, 1'b0, 1'b1);
            checks++;
            if (alu_value !== ex[i] || alu_dependency !== 4'(i + 8))
                begin failures++; $display("FAIL shift_cmp[%0d]: got %h/%0d want %h/%0d", i, alu_value, alu_dependency, ex[i], i + 8); end
            idle(1'b1);
        end
    endtask

    task automatic test_back_to_back();
        for (int t = 1; t <= 3; t++) begin
            cycle(1'b1, 3'd0, 1'b0, 32'(t * 100), 32'(t), 4'(t), 1'b0, 1'b0, 1'b1);
            checks++;
            if (alu_full !== (t == 3)) begin failures++; $display("FAIL bp_full[%0d]: got %b want %b", t, alu_full, t == 3); end
        end
        cycle(1'b1, 3'd0, 1'b0, 32'd400, 32'd4, 4'd4, 1'b0, 1'b0, 1'b1);
        checks++; if (alu_full !== 1'b1 || alu_dependency !== 4'd1) begin failures++; $display("FAIL bp_fourth: got full=%b dep=%0d want 1/1", alu_full, alu_dependency); end
        cycle(1'b1, 3'd6, 1'b0, 32'h00F0, 32'h0F00, 4'd5, 1'b1, 1'b0, 1'b1);
        checks++; if (alu_dependency !== 4'd2 || alu_full !== 1'b1 || alu_value !== 32'd202) begin failures++; $display("FAIL pushpop_full: got dep=%0d full=%b val=%0d want 2/1/202", alu_dependency, alu_full, alu_value); end
        for (int t = 2; t <= 5; t++) begin
            checks++;
            if (alu_dependency !== 4'(t) || alu_value !== m_value() || alu_valid !== 1'b1)
                begin failures++; $display("FAIL drain[%0d]: got dep=%0d val=%h want %0d/%h", t, alu_dependency, alu_value, t, m_value()); end
            idle(1'b1);
        end
        checks++; if (alu_valid !== 1'b0) begin failures++; $display("FAIL drain_empty: got %b want 0", alu_valid); end
    endtask

    task automatic test_flush();
        for (int t = 1; t <= 3; t++) cycle(1'b1, 3'd4, 1'b0, 32'hA5A5_0000, 32'(t), 4'(t), 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 3'd0, 1'b0, 32'd1, 32'd1, 4'd9, 1'b1, 1'b1, 1'b1);
        checks++; if (alu_valid !== 1'b0 || alu_full !== 1'b0) begin failures++; $display("FAIL flush_clear: got valid=%b full=%b want 0/0", alu_valid, alu_full); end
        cycle(1'b1, 3'd7, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'd7, 1'b0, 1'b0, 1'b1);
        checks++; if (alu_dependency !== 4'd7 || alu_value !== 32'h0F00_0F00) begin failures++; $display("FAIL flush_after: got dep=%0d val=%h want 7/0f000f00", alu_dependency, alu_value); end
        idle(1'b1);
        checks++; if (alu_valid !== 1'b0) begin failures++; $display("FAIL flush_stale: got valid=%b dep=%0d want 0", alu_valid, alu_dependency); end
    endtask

    task automatic test_freeze();
        cycle(1'b1, 3'd0, 1'b0, 32'd10, 32'd20, 4'd11, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 3'd0, 1'b0, 32'd30, 32'd40, 4'd12, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 3'd0, 1'b0, 32'd1, 32'd1, 4'd15, 1'b1, 1'b0, 1'b0);
            checks++;
            if (alu_valid !== 1'b1 || alu_value !== 32'd30 || alu_dependency !== 4'd11 || alu_full !== 1'b0)
                begin failures++; $display("FAIL freeze[%0d]: got %b/%0d/%0d want 1/30/11", i, alu_valid, alu_value, alu_dependency); end
        end
        idle(1'b1);
        checks++; if (alu_dependency !== 4'd12 || alu_value !== 32'd70) begin failures++; $display("FAIL freeze_count: got dep=%0d val=%0d want 12/70", alu_dependency, alu_value); end
        idle(1'b1);
        checks++; if (alu_valid !== 1'b0) begin failures++; $display("FAIL freeze_drain: got %b want 0", alu_valid); end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 3'd0, 1'b0, 32'd1, 32'd2, 4'd6, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 3'd0, 1'b0, 32'd3, 32'd4, 4'd7, 1'b0, 1'b0, 1'b1);
        #2 rst_n_in = 1'b0;
        #1;
        checks++; if (alu_valid !== 1'b0 || alu_full !== 1'b0) begin failures++; $display("FAIL async_reset: got valid=%b full=%b want 0/0", alu_valid, alu_full); end
        mq.delete();
        @(negedge clk_in); rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        idle(1'b1);
        checks++; if (alu_valid !== 1'b0) begin failures++; $display("FAIL post_reset: got %b want 0", alu_valid); end
    endtask

    task automatic test_random();
        logic g, iv, fl, rdy;
        for (int i = 0; i < 400; i++) begin
            g   = ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 9) != 0);
            fl  = ($urandom_range(0, 39) == 0);
            iv  = ($urandom_range(0, 3) != 0) && (mq.size() < DEPTH || (g && rdy));
            cycle(iv, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom(),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom(),
                  4'($urandom_range(0, 15)), g, fl, rdy);
            checks++;
            if (alu_valid !== m_valid() || alu_value !== m_value() || alu_dependency !== m_dep() || alu_full !== m_full())
                begin failures++; $display("FAIL random[%0d]: got %b/%h/%0d/%b want %b/%h/%0d/%b", i,
                    alu_valid, alu_value, alu_dependency, alu_full, m_valid(), m_value(), m_dep(), m_full()); end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shift_compare();
        test_back_to_back();
        test_flush();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
